// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response
// channel and the buffered instruction channel toward decode.
// The master side is the fetch unit; the slave side is its environment.
interface fetch_unit_if #(
   parameter int XLEN = 32,
   parameter int ILEN = 32
);
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_address;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_address;
   logic            imem_resp_valid;
   logic [ILEN-1:0] imem_resp_data;
   logic            instr_valid;
   logic            instr_ready;
   logic [ILEN-1:0] instr_data;
   logic [XLEN-1:0] instr_pc;

   modport master (
      input  redirect_valid,
      input  redirect_address,
      output imem_req_valid,
      input  imem_req_ready,
      output imem_req_address,
      input  imem_resp_valid,
      input  imem_resp_data,
      output instr_valid,
      input  instr_ready,
      output instr_data,
      output instr_pc
   );

   modport slave (
      output redirect_valid,
      output redirect_address,
      input  imem_req_valid,
      output imem_req_ready,
      input  imem_req_address,
      output imem_resp_valid,
      output imem_resp_data,
      input  instr_valid,
      output instr_ready,
      input  instr_data,
      input  instr_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Program counter and instruction fetch stage. Issues one instruction-memory
// request at a time, buffers returned words with their PC in a small FIFO
// toward decode, and flushes all in-flight and buffered work on a redirect.
module fetch_unit #(
   parameter int              XLEN         = 32,
   parameter int              ILEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              PC_INCREMENT = 4,
   parameter int              BUF_DEPTH    = 2
) (
   input  logic  clk,
   input  logic  rst,
   fetch_unit_if.master bus
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(BUF_DEPTH);
   localparam logic [XLEN-1:0] INC_C   = XLEN'(PC_INCREMENT);
   localparam logic [XLEN-1:0] ALIGN_C = ~(XLEN'(3));

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] reqPc_q, reqPc_d;

   logic [CW-1:0]   count_q;
   logic [PW-1:0]   wrPtr_q, rdPtr_q;
   logic [XLEN-1:0] bufPc_q   [BUF_DEPTH];
   logic [ILEN-1:0] bufData_q [BUF_DEPTH];

   logic redirect;
   logic reqValid;
   logic reqFire;
   logic instrValid;
   logic doPush;
   logic doPop;

   assign redirect   = bus.redirect_valid;
   assign reqValid   = ~rst & (state_q == REQ) & (count_q < DEPTH_C) & ~redirect;
   assign reqFire    = reqValid & bus.imem_req_ready;
   assign instrValid = (count_q != '0) & ~redirect;
   assign doPop      = instrValid & bus.instr_ready;

   // Fetch state, PC and the PC of the outstanding request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= REQ;
         pc_q    <= RESET_VECTOR;
         reqPc_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         reqPc_q <= reqPc_d;
      end
   end

   // Next fetch state: a redirect overrides everything, and an outstanding
   // response that has not yet returned must be swallowed in DROP
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      reqPc_d = reqPc_q;
      doPush  = 1'b0;
      if (redirect) begin
         pc_d = bus.redirect_address & ALIGN_C;
         unique case (state_q)
            REQ:     state_d = REQ;
            WAIT:    state_d = bus.imem_resp_valid ? REQ : DROP;
            DROP:    state_d = bus.imem_resp_valid ? REQ : DROP;
            default: state_d = REQ;
         endcase
      end else begin
         unique case (state_q)
            REQ: begin
               if (reqFire) begin
                  reqPc_d = pc_q;
                  pc_d    = pc_q + INC_C;
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (bus.imem_resp_valid) begin
                  doPush  = 1'b1;
                  state_d = REQ;
               end
            end
            DROP: begin
               if (bus.imem_resp_valid) begin
                  state_d = REQ;
               end
            end
            default: state_d = REQ;
         endcase
      end
   end

   // Instruction FIFO: flushed on redirect, push/pop may coincide
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            bufPc_q[i]   <= '0;
            bufData_q[i] <= '0;
         end
      end else if (redirect) begin
         count_q <= '0;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (doPush) begin
            bufPc_q[wrPtr_q]   <= reqPc_q;
            bufData_q[wrPtr_q] <= bus.imem_resp_data;
            wrPtr_q            <= wrPtr_q + PW'(1);
         end
         if (doPop) begin
            rdPtr_q <= rdPtr_q + PW'(1);
         end
         unique case ({doPush, doPop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.imem_req_valid   = reqValid;
   assign bus.imem_req_address = rst ? '0 : pc_q;
   assign bus.instr_valid      = instrValid;
   assign bus.instr_data       = bufData_q[rdPtr_q];
   assign bus.instr_pc         = bufPc_q[rdPtr_q];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage that sits directly downstream of the jump/branch target logic.
- Holds the architectural fetch PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Buffers returned instructions with their PC in a small FIFO toward decode.
- Applies redirects (the branch/jump target address) by flushing all in-flight and buffered work.

Parameters:
- XLEN, 32: address and PC width.
- ILEN, 32: instruction word width.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- PC_INCREMENT, 4: sequential PC step.
- BUF_DEPTH, 2: instruction FIFO entries (power of two, ≥2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- redirect_valid  input  1  one-cycle pulse: replace fetch PC with redirect_address.
- redirect_address  input  XLEN  new fetch target (branch/jump address_out).
- imem_req_valid  output  1  request to instruction memory.
- imem_req_ready  input  1  memory accepts request.
- imem_req_address  output  XLEN  fetch address (current PC).
- imem_resp_valid  input  1  instruction word returned (one per accepted request, in order).
- imem_resp_data  input  ILEN  returned instruction.
- instr_valid  output  1  buffered instruction available to decode.
- instr_ready  input  1  decode consumes the head entry.
- instr_data  output  ILEN  head instruction.
- instr_pc  output  XLEN  PC of head instruction.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_VECTOR, state=REQ, FIFO empty.
  - imem_req_valid=0, instr_valid=0.
  - imem_req_address, instr_data and instr_pc are 0.
- State machine states: REQ, WAIT, DROP.
- Request issue, REQ:
  - imem_req_valid=1 when FIFO count < BUF_DEPTH and redirect_valid=0.
  - imem_req_address=pc.
  - On valid&ready: req_pc<=pc; pc<=pc+PC_INCREMENT (mod 2^XLEN, wraps silently); state<=WAIT.
  - First request is visible in the first cycle after rst deasserts.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid: push {req_pc, imem_resp_data} into the FIFO; state<=REQ.
  - A response never arrives in the cycle its request is accepted, so minimum fetch latency to instr_valid is 2 cycles.
- DROP:
  - imem_req_valid=0.
  - On imem_resp_valid: discard the response; state<=REQ.
- Redirect (highest priority, any state):
  - pc<=redirect_address with bits [1:0] forced to 0.
  - FIFO count<=0, pointers reset.
  - instr_valid is forced to 0 combinationally in the redirect cycle, so no decode handshake completes that cycle.
  - The request handshake is suppressed in the redirect cycle.
- Redirect next-state rules:
  - REQ → REQ.
  - WAIT with resp_valid in the same cycle: response discarded, → REQ.
  - WAIT without resp_valid → DROP.
  - DROP with resp_valid → REQ.
  - DROP without resp_valid → stay DROP, with the new pc held.
- Back-to-back redirects: the last one wins; no request is issued between them.
- FIFO:
  - instr_valid = (count≠0) & ~redirect_valid. Head fields drive instr_data and instr_pc.
  - Pop on instr_valid&instr_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Overflow is impossible by construction: a request issues only with a free slot, at most one is outstanding, and the slot is reserved on acceptance.
  - Flow control: instr_ready held low fills the FIFO and stalls requests. Pops reopen REQ on the next cycle.
- Memory not ready: imem_req_valid and imem_req_address hold stable until accepted, unless a redirect occurs. On redirect, valid drops for that cycle and the new address appears the next cycle.
- No combinational path from imem_resp_* to any output.
- The paths redirect_valid→instr_valid and redirect_valid→imem_req_valid are combinational.

Test Plan:
- Reset release with imem_req_ready=1 and memory latency 1 → requests at 0x0, 0x4, 0x8. Decode sees instr_pc 0x0, then 0x4, with matching data. instr_valid first rises 2 cycles after the first acceptance.
- instr_ready=0 for 10 cycles → FIFO holds 2 entries (0x0, 0x4). imem_req_valid stays 0 after the second fill. Raising instr_ready drains 0x0 then 0x4, and fetch resumes at 0x8.
- Redirect to 0x100 while in WAIT (response due next cycle) → that response is discarded (DROP). The next request address is 0x100, and no instruction with pc 0x8 ever reaches decode.
- Redirect to 0x203 in the same cycle as resp_valid in WAIT → response discarded, state REQ. The next request address is 0x200, and FIFO entries are flushed with instr_valid=0 that cycle.
- Set pc near wrap via redirect to 0xFFFF_FFFC → requests at 0xFFFF_FFFC, then 0x0000_0000.
- Assert rst mid-WAIT → all outputs go to reset values immediately. After release, the first request is at RESET_VECTOR, and a late response arriving while rst=1 is ignored.
